mips_cache_mem_arbiter: RTL and testbench

Sequences the single Avalon-MM data-memory master shared by the cache write buffer drain and cache line-fill reads. Read misses preempt buffered writes only at a write-transaction boundary. When the missing line is still held in the write buffer, the arbiter first drains the buffer to keep memory coherent. It sits between mips_cache_writebuffer, the cache controller and the data-side Avalon bus.

---
 rtl/mips_cache_pkg.sv | 23 ++
 rtl/mips_cache_mem_arbiter_if.sv | 27 ++
 rtl/mips_cache_line_counter.sv | 26 ++
 rtl/mips_cache_mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mips_cache_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_cache_pkg.sv
// Shared types for the MIPS cache memory side: arbiter state encoding,
// write buffer fill-state encoding and the default line geometry.
package mips_cache_pkg;

  // Arbiter states; encoding is visible on the debug state_out port.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WRITE = 2'd1,
    ARB_READ  = 2'd2,
    ARB_FLUSH = 2'd3
  } arb_state_t;

  // Write buffer occupancy as seen by mips_cache_writebuffer.
  typedef enum logic [1:0] {
    WB_EMPTY   = 2'd0,
    WB_PARTIAL = 2'd1,
    WB_FULL    = 2'd2
  } wb_state_t;

  // log2 of 32-bit words per cache line.
  localparam int LINE_BITS_DEFAULT = 2;

endpackage

// File: rtl/mips_cache_mem_arbiter_if.sv
// Data-side Avalon-MM bus between the cache memory arbiter (master) and
// the memory system (slave).
//
// Handshake: a transfer is requested while avm_read or avm_write is high
// and completes in the cycle where avm_waitrequest is low. While
// avm_waitrequest is high the master holds address, writedata,
// byteenable, read and write stable. Read data is valid in the completing
// cycle; there is no read pipelining.
interface mips_cache_mem_arbiter_if;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  avm_waitrequest, avm_readdata
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    output avm_waitrequest, avm_readdata
  );
endinterface

// File: rtl/mips_cache_line_counter.sv
// Word index within a cache line fill, with last-word detect.
module mips_cache_line_counter #(
  parameter int LINE_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  output logic [LINE_BITS-1:0] idx,
  output logic                 last
);

  // Index clears at the start of each fill and wraps naturally after the last word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx + 1'b1;
    end
  end

  assign last = &idx;

endmodule

// File: rtl/mips_cache_mem_arbiter.sv
// Shares the single data-side Avalon master between write buffer drain
// and cache line-fill reads. Reads preempt writes only at a write
// boundary; a read whose line is still buffered first flushes the buffer.
// Optional macro MIPS_CACHE_ARB_FAIR_EN: with a full write buffer, one
// extra write is granted at the boundary before a pending read takes over.
module mips_cache_mem_arbiter
  import mips_cache_pkg::*;
#(
  parameter int LINE_BITS = LINE_BITS_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_req,
  input  logic [31:0]             rd_addr,
  output logic [31:0]             rd_word,
  output logic                    rd_word_valid,
  output logic [LINE_BITS-1:0]    rd_word_idx,
  output logic                    rd_done,
  input  logic                    wb_write,
  input  logic [31:0]             wb_addr,
  input  logic [31:0]             wb_data,
  input  logic [3:0]              wb_byteenable,
  input  logic                    wb_empty,
  input  logic                    wb_full,
  input  logic                    wb_addr_in_wb,
  output logic                    wb_active,
  output logic                    wb_waitrequest,
  mips_cache_mem_arbiter_if.master avm,
  output logic [1:0]              state_out
);

  arb_state_t           state_q, state_d;
  arb_state_t           read_target;
  logic [31:0]          line_addr_q;
  logic [31:0]          word_off;
  logic [LINE_BITS-1:0] word_idx;
  logic                 last_word;
  logic                 latch_addr;
  logic                 cnt_clr;
  logic                 rd_complete;
  logic                 wr_done;
  logic                 wr_idle;
  logic                 bonus_set;
  logic                 bonus_take;

  // A buffered copy of the line must reach memory before the line is read.
  assign read_target = (wb_addr_in_wb && !wb_empty) ? ARB_FLUSH : ARB_READ;
  // Write-side qualifiers, only meaningful in WRITE/FLUSH.
  assign wr_done     = wb_write && !avm.avm_waitrequest;
  assign wr_idle     = !wb_write || wr_done;
  assign rd_complete = (state_q == ARB_READ) && !avm.avm_waitrequest;
  assign word_off    = {{(30-LINE_BITS){1'b0}}, word_idx, 2'b00};

  assign rd_word     = avm.avm_readdata;
  assign rd_word_idx = word_idx;
  assign state_out   = state_q;

  mips_cache_line_counter #(
    .LINE_BITS (LINE_BITS)
  ) u_line_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (rd_complete),
    .idx  (word_idx),
    .last (last_word)
  );

`ifdef MIPS_CACHE_ARB_FAIR_EN
  logic bonus_q;

  // Extra-write credit: one per stay in WRITE, forgotten on leaving it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bonus_q <= 1'b0;
    end else if (state_d != ARB_WRITE) begin
      bonus_q <= 1'b0;
    end else if (bonus_set) begin
      bonus_q <= 1'b1;
    end
  end

  assign bonus_take = wr_done && wb_full && !bonus_q;
`else
  logic unused_fair;
  assign unused_fair = wb_full ^ bonus_set;
  assign bonus_take  = 1'b0;
`endif

  // State register and latched line base address.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      line_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_addr) begin
        line_addr_q <= rd_addr;
      end
    end
  end

  // Next-state arbitration; reads only enter once no write is outstanding.
  always_comb begin
    state_d    = state_q;
    latch_addr = 1'b0;
    cnt_clr    = 1'b0;
    bonus_set  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (rd_req) begin
          state_d    = read_target;
          latch_addr = 1'b1;
          cnt_clr    = 1'b1;
        end else if (wb_write) begin
          state_d = ARB_WRITE;
        end
      end
      ARB_WRITE: begin
        if (wr_idle) begin
          if (rd_req) begin
            if (bonus_take) begin
              bonus_set = 1'b1;
            end else begin
              state_d    = read_target;
              latch_addr = 1'b1;
              cnt_clr    = 1'b1;
            end
          end else if (!wb_write) begin
            state_d = ARB_IDLE;
          end
        end
      end
      ARB_FLUSH: begin
        if (wb_empty && wr_idle) begin
          state_d = ARB_READ;
          cnt_clr = 1'b1;
        end
      end
      ARB_READ: begin
        if (rd_complete && last_word) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Bus and handshake outputs, decoded from the current state only.
  always_comb begin
    avm.avm_address    = '0;
    avm.avm_read       = 1'b0;
    avm.avm_write      = 1'b0;
    avm.avm_writedata  = '0;
    avm.avm_byteenable = '0;
    wb_active          = 1'b0;
    wb_waitrequest     = 1'b1;
    rd_word_valid      = 1'b0;
    rd_done            = 1'b0;
    case (state_q)
      ARB_WRITE, ARB_FLUSH: begin
        wb_active          = 1'b1;
        avm.avm_write      = wb_write;
        avm.avm_address    = wb_addr;
        avm.avm_writedata  = wb_data;
        avm.avm_byteenable = wb_byteenable;
        wb_waitrequest     = avm.avm_waitrequest;
      end
      ARB_READ: begin
        avm.avm_read       = 1'b1;
        avm.avm_address    = line_addr_q + word_off;
        avm.avm_byteenable = 4'hF;
        rd_word_valid      = rd_complete;
        rd_done            = rd_complete && last_word;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_cache_mem_arbiter.sv
// Directed bench for mips_cache_mem_arbiter (LINE_BITS = 2).
module tb_mips_cache_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [31:0] rd_word;
  logic        rd_word_valid;
  logic [1:0]  rd_word_idx;
  logic        rd_done;
  logic        wb_write;
  logic [31:0] wb_addr;
  logic [31:0] wb_data;
  logic [3:0]  wb_byteenable;
  logic        wb_empty;
  logic        wb_full;
  logic        wb_addr_in_wb;
  logic        wb_active;
  logic        wb_waitrequest;
  logic [1:0]  state_out;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int wr_base;
  int done_base;

  mips_cache_mem_arbiter_if avm_bus();

  mips_cache_mem_arbiter #(.LINE_BITS(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .rd_word        (rd_word),
    .rd_word_valid  (rd_word_valid),
    .rd_word_idx    (rd_word_idx),
    .rd_done        (rd_done),
    .wb_write       (wb_write),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .wb_byteenable  (wb_byteenable),
    .wb_empty       (wb_empty),
    .wb_full        (wb_full),
    .wb_addr_in_wb  (wb_addr_in_wb),
    .wb_active      (wb_active),
    .wb_waitrequest (wb_waitrequest),
    .avm            (avm_bus.master),
    .state_out      (state_out)
  );

  // Clock and timeout guard.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  // Completed transfers counted mid-cycle, independent of the directed checks.
  always @(negedge clk) begin
    if (avm_bus.avm_write === 1'b1 && avm_bus.avm_waitrequest === 1'b0) wr_cnt++;
    if (avm_bus.avm_read === 1'b1 && avm_bus.avm_waitrequest === 1'b0) rd_cnt++;
    if (rd_done === 1'b1) done_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Completes a full 4-word line at base with no wait states.
  task automatic run_line(input logic [31:0] base);
    logic [31:0] word;
    for (int i = 0; i < 4; i++) begin
      word = 32'hCAFE_0000 | base | 32'(i);
      avm_bus.avm_waitrequest = 1'b0;
      avm_bus.avm_readdata    = word;
      #2;
      check_eq("line_state", 32'(state_out), 32'd2);
      check_eq("line_read", 32'(avm_bus.avm_read), 32'd1);
      check_eq("line_write", 32'(avm_bus.avm_write), 32'd0);
      check_eq("line_addr", avm_bus.avm_address, base + 32'(4 * i));
      check_eq("line_be", 32'(avm_bus.avm_byteenable), 32'hF);
      check_eq("line_valid", 32'(rd_word_valid), 32'd1);
      check_eq("line_idx", 32'(rd_word_idx), 32'(i));
      check_eq("line_word", rd_word, word);
      check_eq("line_done", 32'(rd_done), (i == 3) ? 32'd1 : 32'd0);
      next_cycle;
    end
  endtask

  initial begin
    rst = 1'b0; rd_req = 1'b0; rd_addr = '0;
    wb_write = 1'b0; wb_addr = '0; wb_data = '0; wb_byteenable = '0;
    wb_empty = 1'b1; wb_full = 1'b0; wb_addr_in_wb = 1'b0;
    avm_bus.avm_waitrequest = 1'b0; avm_bus.avm_readdata = '0;

    // Reset state.
    next_cycle;
    next_cycle;
    #2;
    check_eq("rst_state", 32'(state_out), 32'd0);
    check_eq("rst_read", 32'(avm_bus.avm_read), 32'd0);
    check_eq("rst_write", 32'(avm_bus.avm_write), 32'd0);
    check_eq("rst_addr", avm_bus.avm_address, 32'd0);
    check_eq("rst_be", 32'(avm_bus.avm_byteenable), 32'd0);
    check_eq("rst_wb_active", 32'(wb_active), 32'd0);
    check_eq("rst_wb_wait", 32'(wb_waitrequest), 32'd1);
    rst = 1'b1;
    next_cycle;

    // Read only: one stall cycle, then four back-to-back words.
    done_base = done_cnt;
    rd_req = 1'b1; rd_addr = 32'h100;
    #2;
    check_eq("rd_idle", 32'(state_out), 32'd0);
    next_cycle;
    avm_bus.avm_waitrequest = 1'b1;
    #2;
    check_eq("rd_stall_read", 32'(avm_bus.avm_read), 32'd1);
    check_eq("rd_stall_addr", avm_bus.avm_address, 32'h100);
    check_eq("rd_stall_valid", 32'(rd_word_valid), 32'd0);
    next_cycle;
    run_line(32'h100);
    rd_req = 1'b0;
    #2;
    check_eq("rd_back_idle", 32'(state_out), 32'd0);
    check_eq("rd_back_read", 32'(avm_bus.avm_read), 32'd0);
    check_eq("rd_done_count", 32'(done_cnt - done_base), 32'd1);
    next_cycle;

    // Write only: three entries, two wait states on the first.
    wr_base = wr_cnt;
    wb_write = 1'b1; wb_empty = 1'b0; wb_addr = 32'h40; wb_data = 32'h11;
    wb_byteenable = 4'h3; avm_bus.avm_waitrequest = 1'b1;
    #2;
    check_eq("wr_idle_write", 32'(avm_bus.avm_write), 32'd0);
    next_cycle;
    for (int s = 0; s < 2; s++) begin
      #2;
      check_eq("wr_hold_write", 32'(avm_bus.avm_write), 32'd1);
      check_eq("wr_hold_addr", avm_bus.avm_address, 32'h40);
      check_eq("wr_hold_data", avm_bus.avm_writedata, 32'h11);
      check_eq("wr_hold_be", 32'(avm_bus.avm_byteenable), 32'h3);
      check_eq("wr_hold_active", 32'(wb_active), 32'd1);
      check_eq("wr_hold_wbwait", 32'(wb_waitrequest), 32'd1);
      next_cycle;
    end
    avm_bus.avm_waitrequest = 1'b0;
    #2;
    check_eq("wr_first_addr", avm_bus.avm_address, 32'h40);
    check_eq("wr_first_wbwait", 32'(wb_waitrequest), 32'd0);
    next_cycle;
    wb_addr = 32'h44; wb_data = 32'h22; wb_byteenable = 4'hF;
    #2;
    check_eq("wr_second_state", 32'(state_out), 32'd1);
    check_eq("wr_second_addr", avm_bus.avm_address, 32'h44);
    next_cycle;
    wb_addr = 32'h48; wb_data = 32'h33;
    #2;
    check_eq("wr_third_data", avm_bus.avm_writedata, 32'h33);
    check_eq("wr_third_active", 32'(wb_active), 32'd1);
    next_cycle;
    wb_write = 1'b0; wb_empty = 1'b1;
    #2;
    check_eq("wr_drained_state", 32'(state_out), 32'd1);
    check_eq("wr_drained_write", 32'(avm_bus.avm_write), 32'd0);
    next_cycle;
    #2;
    check_eq("wr_end_state", 32'(state_out), 32'd0);
    check_eq("wr_count", 32'(wr_cnt - wr_base), 32'd3);
    next_cycle;

    // Read request during a stalled write: write finishes, read preempts the next entry.
    wr_base = wr_cnt;
    wb_write = 1'b1; wb_empty = 1'b0; wb_addr = 32'h80; wb_data = 32'h55;
    avm_bus.avm_waitrequest = 1'b1;
    #2;
    next_cycle;
    rd_req = 1'b1; rd_addr = 32'h300;
    #2;
    check_eq("pre_stall_state", 32'(state_out), 32'd1);
    check_eq("pre_stall_write", 32'(avm_bus.avm_write), 32'd1);
    check_eq("pre_stall_read", 32'(avm_bus.avm_read), 32'd0);
    next_cycle;
    avm_bus.avm_waitrequest = 1'b0;
    #2;
    check_eq("pre_done_state", 32'(state_out), 32'd1);
    check_eq("pre_done_addr", avm_bus.avm_address, 32'h80);
    next_cycle;
    wb_addr = 32'h84; wb_data = 32'h56;
    avm_bus.avm_waitrequest = 1'b1;
    #2;
    check_eq("pre_read_state", 32'(state_out), 32'd2);
    check_eq("pre_read_write", 32'(avm_bus.avm_write), 32'd0);
    check_eq("pre_read_active", 32'(wb_active), 32'd0);
    check_eq("pre_read_addr", avm_bus.avm_address, 32'h300);
    next_cycle;
    run_line(32'h300);
    rd_req = 1'b0;
    #2;
    check_eq("pre_idle", 32'(state_out), 32'd0);
    next_cycle;
    #2;
    check_eq("pre_resume_state", 32'(state_out), 32'd1);
    check_eq("pre_resume_addr", avm_bus.avm_address, 32'h84);
    next_cycle;
    wb_write = 1'b0; wb_empty = 1'b1;
    #2;
    next_cycle;
    #2;
    check_eq("pre_end_state", 32'(state_out), 32'd0);
    check_eq("pre_wr_count", 32'(wr_cnt - wr_base), 32'd2);
    next_cycle;

    // Missing line still buffered: flush both entries, then read.
    wr_base = wr_cnt;
    rd_req = 1'b1; rd_addr = 32'h200; wb_addr_in_wb = 1'b1;
    wb_write = 1'b1; wb_empty = 1'b0; wb_addr = 32'h200; wb_data = 32'h77;
    #2;
    check_eq("fl_idle", 32'(state_out), 32'd0);
    next_cycle;
    #2;
    check_eq("fl_state", 32'(state_out), 32'd3);
    check_eq("fl_write", 32'(avm_bus.avm_write), 32'd1);
    check_eq("fl_read", 32'(avm_bus.avm_read), 32'd0);
    check_eq("fl_active", 32'(wb_active), 32'd1);
    next_cycle;
    wb_addr = 32'h204; wb_data = 32'h78;
    #2;
    check_eq("fl_second_state", 32'(state_out), 32'd3);
    check_eq("fl_second_addr", avm_bus.avm_address, 32'h204);
    next_cycle;
    wb_write = 1'b0; wb_empty = 1'b1; wb_addr_in_wb = 1'b0;
    #2;
    check_eq("fl_empty_state", 32'(state_out), 32'd3);
    check_eq("fl_empty_read", 32'(avm_bus.avm_read), 32'd0);
    next_cycle;
    run_line(32'h200);
    rd_req = 1'b0;
    #2;
    check_eq("fl_end_state", 32'(state_out), 32'd0);
    check_eq("fl_wr_count", 32'(wr_cnt - wr_base), 32'd2);
    next_cycle;

    // Full buffer with a read pending at a write boundary.
    wr_base = wr_cnt;
    wb_write = 1'b1; wb_empty = 1'b0; wb_full = 1'b1; wb_addr = 32'h10; wb_data = 32'h99;
    #2;
    next_cycle;
    rd_req = 1'b1; rd_addr = 32'h400;
    #2;
    check_eq("fair_first_state", 32'(state_out), 32'd1);
    next_cycle;
    wb_addr = 32'h14; wb_data = 32'h9A;
`ifdef MIPS_CACHE_ARB_FAIR_EN
    #2;
    check_eq("fair_bonus_state", 32'(state_out), 32'd1);
    check_eq("fair_bonus_addr", avm_bus.avm_address, 32'h14);
    next_cycle;
    wb_addr = 32'h18; wb_data = 32'h9B;
`endif
    run_line(32'h400);
    rd_req = 1'b0; wb_write = 1'b0; wb_empty = 1'b1; wb_full = 1'b0;
    #2;
    check_eq("fair_end_state", 32'(state_out), 32'd0);
`ifdef MIPS_CACHE_ARB_FAIR_EN
    check_eq("fair_wr_count", 32'(wr_cnt - wr_base), 32'd2);
`else
    check_eq("fair_wr_count", 32'(wr_cnt - wr_base), 32'd1);
`endif
    next_cycle;

    // Reset during word 2 of a read aborts without rd_done.
    done_base = done_cnt;
    rd_req = 1'b1; rd_addr = 32'h500; avm_bus.avm_waitrequest = 1'b0;
    #2;
    next_cycle;
    next_cycle;
    next_cycle;
    rst = 1'b0;
    #2;
    check_eq("rr_word2_idx", 32'(rd_word_idx), 32'd2);
    next_cycle;
    #2;
    check_eq("rr_state", 32'(state_out), 32'd0);
    check_eq("rr_read", 32'(avm_bus.avm_read), 32'd0);
    check_eq("rr_addr", avm_bus.avm_address, 32'd0);
    check_eq("rr_be", 32'(avm_bus.avm_byteenable), 32'd0);
    check_eq("rr_valid", 32'(rd_word_valid), 32'd0);
    check_eq("rr_done", 32'(rd_done), 32'd0);
    rst = 1'b1; rd_req = 1'b0;
    next_cycle;
    #2;
    check_eq("rr_after_state", 32'(state_out), 32'd0);
    check_eq("rr_done_count", 32'(done_cnt - done_base), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
